// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the main ALU and the multi-cycle multiply/divide sequencer:
// flag vector bit positions, the muldiv operation encoding, sequencer states and
// a helper that assembles a flag vector in the common bit order.
package alu_muldiv_seq_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WIDE_W = 16;
   localparam int unsigned FLAG_W = 4;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      FLAG_Z = 2'd0,
      FLAG_C = 2'd1,
      FLAG_V = 2'd2,
      FLAG_S = 2'd3
   } flag_idx_e;

   typedef enum logic {
      MULDIV_MLT = 1'b0,
      MULDIV_DIV = 1'b1
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   // Builds a flag vector with each flag at its shared ALU position.
   function automatic logic [FLAG_W-1:0] pack_flags(input logic z, input logic c,
                                                     input logic v, input logic s);
      logic [FLAG_W-1:0] f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      f[FLAG_S] = s;
      return f;
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One combinational step of either shift-add multiply or restoring divide.
// Ports:
//   op      - operation (MLT / DIV)
//   acc_in  - MLT: product accumulator; DIV: partial remainder
//   sh_in   - MLT: remaining multiplier (LSB first); DIV: dividend bits in, quotient bits out
//   operand - MLT: multiplicand; DIV: divisor
//   bit_idx - MLT: weight of the multiplier bit being retired
//   acc_out, sh_out - state after this step
module muldiv_step
   import alu_muldiv_seq_pkg::*;
(
   input  muldiv_op_e        op,
   input  logic [WIDE_W-1:0] acc_in,
   input  logic [BYTE_W-1:0] sh_in,
   input  logic [BYTE_W-1:0] operand,
   input  logic [IDX_W-1:0]  bit_idx,
   output logic [WIDE_W-1:0] acc_out,
   output logic [BYTE_W-1:0] sh_out
);

   logic [WIDE_W-1:0] addend;
   logic [WIDE_W-1:0] trial;

   // DIV reuses the dividend shifter: dividend MSBs leave at the top while
   // quotient bits enter at the bottom, so after eight steps it holds the quotient.
   always_comb begin
      acc_out = acc_in;
      sh_out  = sh_in;
      addend  = WIDE_W'(operand) << bit_idx;
      trial   = {acc_in[WIDE_W-2:0], sh_in[BYTE_W-1]};
      if (op == MULDIV_MLT) begin
         if (sh_in[0]) begin
            acc_out = acc_in + addend;
         end
         sh_out = {1'b0, sh_in[BYTE_W-1:1]};
      end else if (trial >= WIDE_W'(operand)) begin
         acc_out = trial - WIDE_W'(operand);
         sh_out  = {sh_in[BYTE_W-2:0], 1'b1};
      end else begin
         acc_out = trial;
         sh_out  = {sh_in[BYTE_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle sequencer for 8x8 multiply (HL = L * A) and 16/8 divide
// (L = HL / A, H = HL % A).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   start, op, hl, a     - launch request and operands (sampled when not busy)
//   busy                 - operation in progress
//   done                 - one-cycle completion pulse
//   result, flags, div_zero - outcome, held until the next completion
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1   // 1, 2, 4 or 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [WIDE_W-1:0] hl,
   input  logic [BYTE_W-1:0] a,
   output logic              busy,
   output logic              done,
   output logic [WIDE_W-1:0] result,
   output logic [FLAG_W-1:0] flags,
   output logic              div_zero
);

   localparam int unsigned RUN_CYCLES = BYTE_W / BITS_PER_CYCLE;
   localparam int unsigned RUN_LAST   = RUN_CYCLES - 1;

   muldiv_state_e     state, state_next;
   muldiv_op_e        op_in, op_q;
   logic [WIDE_W-1:0] acc_q, acc_fin, res_fin;
   logic [BYTE_W-1:0] sh_q, sh_fin, opnd_q;
   logic [FLAG_W-1:0] flags_fin;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  base_idx;
   logic              accept, fast, last;

   assign op_in  = muldiv_op_e'(op);
   assign accept = start && (state != ST_RUN);
   // A zero divisor also satisfies this compare, so both early exits share it.
   assign fast   = (op_in == MULDIV_DIV) && (hl[WIDE_W-1:BYTE_W] >= a);
   assign last   = (cnt_q == '0);
   // Multiplier weight of the first step this cycle.
   assign base_idx = IDX_W'((RUN_LAST - 32'(cnt_q)) * BITS_PER_CYCLE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = fast ? ST_DONE : ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      if (state == ST_RUN) begin
         busy = 1'b1;
      end
      if (state == ST_DONE) begin
         done = 1'b1;
      end
   end

   // Chain of single-bit steps retired in one RUN cycle.
   for (genvar j = 0; j < int'(BITS_PER_CYCLE); j++) begin : g_step
      logic [WIDE_W-1:0] acc_i, acc_o;
      logic [BYTE_W-1:0] sh_i, sh_o;
      if (j == 0) begin : g_first
         assign acc_i = acc_q;
         assign sh_i  = sh_q;
      end else begin : g_next
         assign acc_i = g_step[j-1].acc_o;
         assign sh_i  = g_step[j-1].sh_o;
      end
      muldiv_step u_step (
         .op      (op_q),
         .acc_in  (acc_i),
         .sh_in   (sh_i),
         .operand (opnd_q),
         .bit_idx (base_idx + IDX_W'(j)),
         .acc_out (acc_o),
         .sh_out  (sh_o)
      );
   end

   assign acc_fin = g_step[BITS_PER_CYCLE-1].acc_o;
   assign sh_fin  = g_step[BITS_PER_CYCLE-1].sh_o;

   // Final result and flags from the last RUN cycle's chain output.
   always_comb begin
      if (op_q == MULDIV_MLT) begin
         res_fin   = acc_fin;
         flags_fin = pack_flags(acc_fin == '0, 1'b0, 1'b0, acc_fin[WIDE_W-1]);
      end else begin
         res_fin   = {acc_fin[BYTE_W-1:0], sh_fin};
         flags_fin = pack_flags(sh_fin == '0, 1'b0, 1'b0, sh_fin[BYTE_W-1]);
      end
   end

   // Operand latch, iteration state and held outcome registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= MULDIV_MLT;
         acc_q    <= '0;
         sh_q     <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         result   <= '0;
         flags    <= '0;
         div_zero <= 1'b0;
      end else if (accept) begin
         op_q  <= op_in;
         cnt_q <= CNT_W'(RUN_LAST);
         if (op_in == MULDIV_DIV) begin
            acc_q  <= {BYTE_W'(0), hl[WIDE_W-1:BYTE_W]};
            sh_q   <= hl[BYTE_W-1:0];
            opnd_q <= a;
         end else begin
            acc_q  <= '0;
            sh_q   <= a;
            opnd_q <= hl[BYTE_W-1:0];
         end
         if (fast) begin
            result   <= hl;
            flags    <= (a == '0) ? '0 : pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
            div_zero <= (a == '0);
         end
      end else if (state == ST_RUN) begin
         acc_q <= acc_fin;
         sh_q  <= sh_fin;
         cnt_q <= cnt_q - CNT_W'(1);
         if (last) begin
            result   <= res_fin;
            flags    <= flags_fin;
            div_zero <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer for the CPU's 8-bit multiply (MLT: HL = L * A) and 16/8 divide (DIV: L = HL / A, H = HL % A). Neither operation fits the single-cycle combinational ALU.
- Microcode launches the operation with a start pulse and stalls on busy.
- It writes back result and flags on the done pulse.
- Flag bit ordering is identical to the main ALU's flag vector.

Parameters:
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per RUN cycle. Legal values are 1, 2, 4, 8. RUN length = 8/BITS_PER_CYCLE cycles.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only when not busy
op  in  1  0 = MLT, 1 = DIV
hl  in  16  MLT: L = hl[7:0] is the multiplicand, hl[15:8] is ignored; DIV: dividend
a  in  8  MLT multiplier / DIV divisor
busy  out  1  high while operation in progress (RUN state)
done  out  1  single-cycle completion pulse
result  out  16  MLT: product; DIV: {remainder, quotient}; held until next accepted start
flags  out  4  [0]=Z, [1]=C, [2]=V, [3]=S; held with result
div_zero  out  1  DIV with a==0; held with result

Behaviour:
- One clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values: state IDLE; busy, done, div_zero = 0; result = 16'h0000; flags = 4'h0.
- Reset has priority over everything, including mid-RUN: the operation is abandoned and there is no done pulse.

States: IDLE, RUN, DONE.
- IDLE/DONE + start → operands latched.
  - op=DIV and a==0 → DONE next cycle. div_zero=1, result=hl, flags=0.
  - op=DIV and hl[15:8] >= a (quotient overflow) → DONE next cycle. V=1, Z=C=S=0, result=hl, div_zero=0.
  - Otherwise → RUN with iteration counter = 8/BITS_PER_CYCLE − 1.
- RUN: busy=1. Each cycle performs BITS_PER_CYCLE steps.
  - Decrement the counter; at counter==0 go to DONE.
  - start is ignored throughout RUN.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or RUN/DONE if start is asserted that same cycle (back-to-back accepted; done still pulses).
- Latency (start-sampled edge to done high): 8/BITS_PER_CYCLE + 1 cycles. With the default this is 9. The fast paths take 1 cycle.
- result/flags/div_zero update only on the transition into DONE. They are stable from then until the next such transition.

MLT step (shift-add, unsigned):
- 16-bit accumulator, multiplier shifted right.
- Add multiplicand << bit index when the multiplier LSB is 1.
- No carries are lost, since 255*255 fits in 16 bits.
- Flags: Z = (product==0), S = product[15], C=0, V=0.

DIV step (restoring, unsigned):
- 16-bit partial remainder starts as {8'h00, hl[15:8]}; the dividend low byte is shifted in MSB-first.
- Compare with a; if remainder >= a, subtract and set the quotient bit to 1, else set it to 0.
- Final result = {remainder[7:0], quotient[7:0]}.
- Flags: Z = (quotient==0), S = quotient[7], C=0, V=0.
- Latched operands are immune to input changes after acceptance.

Decomposition:
- Shared package, also used by the ALU: the flag index enum (Z,C,V,S) and an enum {MULDIV_MLT, MULDIV_DIV}.
- Sub-module muldiv_step: combinational single-bit step, with op, accumulator/remainder, operand and bit in, and updated state out.
  - Instantiate it as a generate chain of BITS_PER_CYCLE copies.

Test Plan:
- MLT hl=16'h000C, a=8'h0B → done 9 cycles after start, result=16'h0084, flags=0. Repeat with BITS_PER_CYCLE=8 → done after 2 cycles, same result.
- MLT hl=16'hAAFF, a=8'hFF → result=16'hFE01, S=1, Z=0. MLT hl=16'h0000, a=8'h37 → result=0, Z=1.
- DIV hl=16'h0103, a=8'h10 → result=16'h0310 (quotient 0x10, remainder 0x03), flags=0, 9-cycle latency.
- DIV hl=16'h1234, a=8'h10 → done 1 cycle after start, V=1, result=16'h1234. DIV a=0 → div_zero=1, result=hl, flags=0.
- Assert start every cycle during RUN with different operands → only the first operation completes and done pulses once. Start in the DONE cycle → second operation completes 9 cycles later.
- Assert reset at RUN cycle 4 → next cycle busy=0, done never pulses, result=0. A new start afterwards computes correctly.
